// File: rtl/lpc_reg_write_arbiter.sv
// rtl/lpc_reg_write_arbiter.sv - Shares the register-file write port between LPC host writes and round-robin internal requesters
module lpc_reg_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input  logic                 LpcClock,
  input  logic                 PciReset,
  input  logic                 LpcWr,
  input  logic [AW-1:0]        LpcAddr,
  input  logic [DW-1:0]        LpcData,
  input  logic [NREQ-1:0]      ReqValid,
  input  logic [NREQ*AW-1:0]   ReqAddr,
  input  logic [NREQ*DW-1:0]   ReqData,
  output logic [NREQ-1:0]      ReqAck,
  output logic                 RegWr,
  output logic [AW-1:0]        RegAddr,
  output logic [DW-1:0]        RegData,
  output logic                 RegSrcHost,
  output logic [7:0]           DeferCnt
);

  // Index width for requester numbers; one bit minimum so NREQ=1 still elaborates.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra bit so pointer + offset can exceed NREQ-1 before wrapping.
  localparam int SW = IW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  // Requester buses unpacked into arrays so the winner can be selected by index.
  logic [AW-1:0] req_addr_a [NREQ];
  logic [DW-1:0] req_data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_addr_a[g] = ReqAddr[g*AW +: AW];
    assign req_data_a[g] = ReqData[g*DW +: DW];
  end

  // State and hold registers.
  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [AW-1:0]   hold_addr_q, hold_addr_d;
  logic [DW-1:0]   hold_data_q, hold_data_d;
  logic [7:0]      defer_q, defer_d;

  // Registered outputs.
  logic            reg_wr_q, reg_wr_d;
  logic            reg_src_host_q, reg_src_host_d;
  logic [AW-1:0]   reg_addr_q, reg_addr_d;
  logic [DW-1:0]   reg_data_q, reg_data_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;

  // Round-robin search results.
  logic            arb_found;
  logic [IW-1:0]   arb_idx;
  logic [SW-1:0]   cand_sum;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   win_next;

  // Pick the first valid requester at or after the pointer, wrapping past NREQ-1.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, ptr_q} + SW'(i);
      if (cand_sum >= SW'(NREQ)) begin
        cand_sum = cand_sum - SW'(NREQ);
      end
      cand = cand_sum[IW-1:0];
      if (!arb_found && ReqValid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Pointer value following the current winner, wrapping to zero.
  always_comb begin
    if (win_q == IW'(NREQ - 1)) begin
      win_next = '0;
    end else begin
      win_next = win_q + 1'b1;
    end
  end

  // Host writes pass straight through; internal writes follow IDLE -> ARB -> ISSUE
  // and are pushed back one cycle for every host write landing in ISSUE.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    win_d          = win_q;
    hold_addr_d    = hold_addr_q;
    hold_data_d    = hold_data_q;
    defer_d        = defer_q;
    reg_wr_d       = 1'b0;
    reg_src_host_d = 1'b0;
    reg_addr_d     = reg_addr_q;
    reg_data_d     = reg_data_q;
    req_ack_d      = '0;

    if (LpcWr) begin
      reg_wr_d       = 1'b1;
      reg_src_host_d = 1'b1;
      reg_addr_d     = LpcAddr;
      reg_data_d     = LpcData;
    end

    case (state_q)
      ST_IDLE: begin
        // Capture commits the request; later ReqValid changes do not cancel it.
        if (!LpcWr && arb_found) begin
          win_d       = arb_idx;
          hold_addr_d = req_addr_a[arb_idx];
          hold_data_d = req_data_a[arb_idx];
          state_d     = ST_ARB;
        end
      end
      ST_ARB: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (LpcWr) begin
          if (defer_q != 8'hFF) begin
            defer_d = defer_q + 8'd1;
          end
        end else begin
          reg_wr_d         = 1'b1;
          reg_src_host_d   = 1'b0;
          reg_addr_d       = hold_addr_q;
          reg_data_d       = hold_data_q;
          req_ack_d[win_q] = 1'b1;
          ptr_d            = win_next;
          state_d          = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbiter state, hold registers and deferral counter.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      defer_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      defer_q     <= defer_d;
    end
  end

  // Register-file write port and acknowledge outputs.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      reg_wr_q       <= 1'b0;
      reg_src_host_q <= 1'b0;
      reg_addr_q     <= '0;
      reg_data_q     <= '0;
      req_ack_q      <= '0;
    end else begin
      reg_wr_q       <= reg_wr_d;
      reg_src_host_q <= reg_src_host_d;
      reg_addr_q     <= reg_addr_d;
      reg_data_q     <= reg_data_d;
      req_ack_q      <= req_ack_d;
    end
  end

  assign RegWr      = reg_wr_q;
  assign RegSrcHost = reg_src_host_q;
  assign RegAddr    = reg_addr_q;
  assign RegData    = reg_data_q;
  assign ReqAck     = req_ack_q;
  assign DeferCnt   = defer_q;

endmodule

// File: tb/tb_lpc_reg_write_arbiter.sv
// tb/tb_lpc_reg_write_arbiter.sv - Scoreboard bench for lpc_reg_write_arbiter
module tb_lpc_reg_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 8;
  localparam int DW   = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 LpcWr;
  logic [AW-1:0]        LpcAddr;
  logic [DW-1:0]        LpcData;
  logic [NREQ-1:0]      ReqValid;
  logic [NREQ*AW-1:0]   ReqAddr;
  logic [NREQ*DW-1:0]   ReqData;
  logic [NREQ-1:0]      ReqAck;
  logic                 RegWr;
  logic [AW-1:0]        RegAddr;
  logic [DW-1:0]        RegData;
  logic                 RegSrcHost;
  logic [7:0]           DeferCnt;

  lpc_reg_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .LpcClock   (clk),
    .PciReset   (rst_n),
    .LpcWr      (LpcWr),
    .LpcAddr    (LpcAddr),
    .LpcData    (LpcData),
    .ReqValid   (ReqValid),
    .ReqAddr    (ReqAddr),
    .ReqData    (ReqData),
    .ReqAck     (ReqAck),
    .RegWr      (RegWr),
    .RegAddr    (RegAddr),
    .RegData    (RegData),
    .RegSrcHost (RegSrcHost),
    .DeferCnt   (DeferCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       host;
    logic [2:0] ack;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic host, input logic [2:0] ack, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{host: host, ack: ack, addr: a, data: d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write strobe or acknowledge seen must match the next expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (RegWr || (ReqAck != '0)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got wr=%0b host=%0b ack=%b addr=0x%0h data=0x%0h expected no write",
                   RegWr, RegSrcHost, ReqAck, RegAddr, RegData);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_strobe", 32'(RegWr), 32'd1);
          check("wr_src_host", 32'(RegSrcHost), 32'(mon_e.host));
          check("wr_ack", 32'(ReqAck), 32'(mon_e.ack));
          check("wr_addr", 32'(RegAddr), 32'(mon_e.addr));
          check("wr_data", 32'(RegData), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus expected finish before 100000 ns");
    $fatal(1, "timeout");
  end

  int n_ack;
  int last_cyc;
  int start_cyc;

  initial begin
    rst_n    = 1'b0;
    LpcWr    = 1'b0;
    LpcAddr  = '0;
    LpcData  = '0;
    ReqValid = '0;
    ReqAddr  = {8'h32, 8'h31, 8'h30};
    ReqData  = {8'h42, 8'h41, 8'h40};
    step();
    step();

    // Reset state
    check("rst_regwr", 32'(RegWr), 32'd0);
    check("rst_addr", 32'(RegAddr), 32'd0);
    check("rst_data", 32'(RegData), 32'd0);
    check("rst_srchost", 32'(RegSrcHost), 32'd0);
    check("rst_ack", 32'(ReqAck), 32'd0);
    check("rst_defer", 32'(DeferCnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Host only write, then address/data hold when idle
    LpcWr = 1'b1; LpcAddr = 8'h01; LpcData = 8'hA5;
    push(1'b1, 3'b000, 8'h01, 8'hA5);
    step();
    LpcWr = 1'b0;
    step();
    check("hold_regwr", 32'(RegWr), 32'd0);
    check("hold_addr", 32'(RegAddr), 32'h01);
    check("hold_data", 32'(RegData), 32'hA5);

    // Round-robin with all three requesting
    push(1'b0, 3'b001, 8'h30, 8'h40);
    push(1'b0, 3'b010, 8'h31, 8'h41);
    push(1'b0, 3'b100, 8'h32, 8'h42);
    push(1'b0, 3'b001, 8'h30, 8'h40);
    ReqValid  = 3'b111;
    n_ack     = 0;
    start_cyc = cyc;
    last_cyc  = cyc;
    for (int k = 0; k < 40 && n_ack < 4; k++) begin
      step();
      if (ReqAck != '0) begin
        if (n_ack == 0) check("rr_first_latency", 32'(cyc - start_cyc), 32'd3);
        else            check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        n_ack++;
        if (n_ack == 4) ReqValid = '0;
      end
    end
    check("rr_ack_count", 32'(n_ack), 32'd4);
    step();
    step();

    // Collision: two host writes land in ISSUE, request dropped after capture
    ReqAddr[15:8] = 8'h10; ReqData[15:8] = 8'h3C;
    ReqValid = 3'b010;
    push(1'b1, 3'b000, 8'h50, 8'h01);
    push(1'b1, 3'b000, 8'h51, 8'h02);
    push(1'b0, 3'b010, 8'h10, 8'h3C);
    step();
    ReqValid = '0;
    step();
    LpcWr = 1'b1; LpcAddr = 8'h50; LpcData = 8'h01;
    step();
    LpcAddr = 8'h51; LpcData = 8'h02;
    step();
    LpcWr = 1'b0;
    step();
    check("col_ack", 32'(ReqAck), 32'b010);
    check("col_defer", 32'(DeferCnt), 32'd2);
    step();

    // Same address: host first, internal later wins
    ReqAddr[7:0] = 8'h20; ReqData[7:0] = 8'h22;
    ReqValid = 3'b001;
    LpcWr = 1'b1; LpcAddr = 8'h20; LpcData = 8'h11;
    push(1'b1, 3'b000, 8'h20, 8'h11);
    push(1'b0, 3'b001, 8'h20, 8'h22);
    step();
    check("same_host_first_ack", 32'(ReqAck), 32'd0);
    LpcWr = 1'b0;
    step();
    step();
    step();
    check("same_int_ack", 32'(ReqAck), 32'b001);
    ReqValid = '0;
    step();

    // Reset mid-ISSUE discards the captured request
    ReqAddr[15:8] = 8'h70; ReqData[15:8] = 8'h55;
    ReqValid = 3'b010;
    step();
    ReqValid = '0;
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_regwr", 32'(RegWr), 32'd0);
    check("mid_rst_addr", 32'(RegAddr), 32'd0);
    check("mid_rst_data", 32'(RegData), 32'd0);
    check("mid_rst_srchost", 32'(RegSrcHost), 32'd0);
    check("mid_rst_ack", 32'(ReqAck), 32'd0);
    check("mid_rst_defer", 32'(DeferCnt), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("post_rst_defer", 32'(DeferCnt), 32'd0);

    // After reset the pointer is back at 0 and latency is nominal
    ReqAddr = {8'h32, 8'h31, 8'h30};
    ReqData = {8'h42, 8'h41, 8'h40};
    ReqValid = 3'b111;
    push(1'b0, 3'b001, 8'h30, 8'h40);
    step();
    step();
    step();
    check("post_rst_ack", 32'(ReqAck), 32'b001);
    ReqValid = '0;
    step();
    step();

    // Saturation: 300 deferrals, internal write still issues exactly once
    ReqAddr[23:16] = 8'h60; ReqData[23:16] = 8'h77;
    ReqValid = 3'b100;
    step();
    ReqValid = '0;
    step();
    for (int i = 0; i < 300; i++) begin
      LpcWr = 1'b1; LpcAddr = 8'(i); LpcData = ~8'(i);
      push(1'b1, 3'b000, 8'(i), ~8'(i));
      step();
    end
    LpcWr = 1'b0;
    push(1'b0, 3'b100, 8'h60, 8'h77);
    step();
    check("sat_ack", 32'(ReqAck), 32'b100);
    check("sat_defer", 32'(DeferCnt), 32'd255);
    for (int k = 0; k < 6; k++) step();
    check("sat_defer_hold", 32'(DeferCnt), 32'd255);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
